// File: rtl/bram1_result_reader_if.sv
// Bundles the BRAM1 read port and the lane stream of bram1_result_reader.
//   addr_b1_o / ce_b1_o / we_b1_o : BRAM1 address, chip enable, write enable
//   q_b1_i                        : BRAM1 read data, one cycle after a ce cycle
//   m_valid_o / m_ready_i         : lane stream handshake
//   m_data_o / m_last_o           : current lane and final-lane flag
// master = reader side, slave = memory + downstream sink side.
interface bram1_result_reader_if #(
   parameter int unsigned DWIDTH_2 = 64,
   parameter int unsigned AWIDTH   = 8
);
   localparam int unsigned OUT_DATA_WIDTH = DWIDTH_2 / 4;

   logic [AWIDTH-1:0]         addr_b1_o;
   logic                      ce_b1_o;
   logic                      we_b1_o;
   logic [DWIDTH_2-1:0]       q_b1_i;
   logic                      m_valid_o;
   logic                      m_ready_i;
   logic [OUT_DATA_WIDTH-1:0] m_data_o;
   logic                      m_last_o;

   modport master (
      output addr_b1_o, ce_b1_o, we_b1_o, m_valid_o, m_data_o, m_last_o,
      input  q_b1_i, m_ready_i
   );

   modport slave (
      input  addr_b1_o, ce_b1_o, we_b1_o, m_valid_o, m_data_o, m_last_o,
      output q_b1_i, m_ready_i
   );
endinterface

// File: rtl/bram1_result_reader.sv
// Drains packed 64-bit result words from BRAM1 and streams them out as four
// 16-bit lanes (MSB lane first) over a valid/ready interface.
//   clk, reset         : single clock, synchronous active-high reset
//   start_run_i        : start pulse, honoured only in IDLE
//   run_count_i        : words to drain, clamped to MEM_SIZE
//   idle_o/run_o/done_o: state flags, done_o is a one-cycle pulse
//   bus (master)       : BRAM1 read port and lane stream
module bram1_result_reader #(
   parameter int unsigned CNT_BIT  = 31,
   parameter int unsigned DWIDTH_2 = 64,
   parameter int unsigned AWIDTH   = 8,
   parameter int unsigned MEM_SIZE = 256
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_run_i,
   input  logic [CNT_BIT-1:0]    run_count_i,
   output logic                  idle_o,
   output logic                  run_o,
   output logic                  done_o,
   bram1_result_reader_if.master bus
);

   localparam int unsigned OUT_DATA_WIDTH = DWIDTH_2 / 4;
   localparam int unsigned WCW            = AWIDTH + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                    state_q, state_n;
   logic [WCW-1:0]            cnt_q, cnt_n;
   logic [WCW-1:0]            issued_q, issued_n;
   logic [WCW-1:0]            retired_q, retired_n;
   logic [DWIDTH_2-1:0]       cur_word_q, cur_word_n;
   logic                      cur_valid_q, cur_valid_n;
   logic [1:0]                lane_q, lane_n;
   logic [DWIDTH_2-1:0]       pf_word_q, pf_word_n;
   logic                      pf_valid_q, pf_valid_n;
   logic                      rd_vld_q, rd_vld_n;
   logic                      ce_q, ce_n;
   logic [AWIDTH-1:0]         addr_q, addr_n;
   logic [OUT_DATA_WIDTH-1:0] m_data_q, m_data_n;
   logic                      m_last_q, m_last_n;
   logic                      idle_q, idle_n;
   logic                      run_q, run_n;
   logic                      done_q, done_n;

   logic [WCW-1:0]            req_cnt_c;
   logic                      hs_c;
   logic                      lane3_hs_c;

   // Lane 0 is the most significant 16 bits of the word.
   function automatic logic [OUT_DATA_WIDTH-1:0] lane_sel(
      input logic [DWIDTH_2-1:0] w,
      input logic [1:0]          lane
   );
      case (lane)
         2'd0:    return w[4*OUT_DATA_WIDTH-1 -: OUT_DATA_WIDTH];
         2'd1:    return w[3*OUT_DATA_WIDTH-1 -: OUT_DATA_WIDTH];
         2'd2:    return w[2*OUT_DATA_WIDTH-1 -: OUT_DATA_WIDTH];
         default: return w[OUT_DATA_WIDTH-1   -: OUT_DATA_WIDTH];
      endcase
   endfunction

   // Clamp the requested count to the BRAM depth.
   always_comb begin
      req_cnt_c = WCW'(run_count_i);
      if (run_count_i > CNT_BIT'(MEM_SIZE)) begin
         req_cnt_c = WCW'(MEM_SIZE);
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         issued_q    <= '0;
         retired_q   <= '0;
         cur_word_q  <= '0;
         cur_valid_q <= 1'b0;
         lane_q      <= '0;
         pf_word_q   <= '0;
         pf_valid_q  <= 1'b0;
         rd_vld_q    <= 1'b0;
         ce_q        <= 1'b0;
         addr_q      <= '0;
         m_data_q    <= '0;
         m_last_q    <= 1'b0;
         idle_q      <= 1'b1;
         run_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_n;
         cnt_q       <= cnt_n;
         issued_q    <= issued_n;
         retired_q   <= retired_n;
         cur_word_q  <= cur_word_n;
         cur_valid_q <= cur_valid_n;
         lane_q      <= lane_n;
         pf_word_q   <= pf_word_n;
         pf_valid_q  <= pf_valid_n;
         rd_vld_q    <= rd_vld_n;
         ce_q        <= ce_n;
         addr_q      <= addr_n;
         m_data_q    <= m_data_n;
         m_last_q    <= m_last_n;
         idle_q      <= idle_n;
         run_q       <= run_n;
         done_q      <= done_n;
      end
   end

   // Next-state, word slots, read issue and registered-output values.
   always_comb begin
      state_n     = state_q;
      cnt_n       = cnt_q;
      issued_n    = issued_q;
      retired_n   = retired_q;
      cur_word_n  = cur_word_q;
      cur_valid_n = cur_valid_q;
      lane_n      = lane_q;
      pf_word_n   = pf_word_q;
      pf_valid_n  = pf_valid_q;
      rd_vld_n    = ce_q;
      ce_n        = 1'b0;
      addr_n      = addr_q;
      m_data_n    = m_data_q;
      m_last_n    = 1'b0;
      idle_n      = 1'b0;
      run_n       = 1'b0;
      done_n      = 1'b0;

      hs_c       = cur_valid_q && bus.m_ready_i;
      lane3_hs_c = hs_c && (lane_q == 2'd3);

      case (state_q)
         S_IDLE: begin
            if (start_run_i) begin
               cnt_n       = req_cnt_c;
               issued_n    = '0;
               retired_n   = '0;
               lane_n      = '0;
               cur_valid_n = 1'b0;
               pf_valid_n  = 1'b0;
               state_n     = (req_cnt_c == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (hs_c && m_last_q) begin
               state_n = S_DONE;
            end
         end
         S_DONE: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase

      // Lane transfer; the last lane hands the prefetched word to current.
      if (hs_c) begin
         if (lane3_hs_c) begin
            retired_n   = retired_q + WCW'(1);
            lane_n      = '0;
            cur_valid_n = pf_valid_q;
            cur_word_n  = pf_word_q;
            pf_valid_n  = 1'b0;
         end else begin
            lane_n = lane_q + 2'd1;
         end
      end

      // Returning read data fills current if it ends up empty, else prefetch.
      if (rd_vld_q) begin
         if (!cur_valid_n) begin
            cur_word_n  = bus.q_b1_i;
            cur_valid_n = 1'b1;
            lane_n      = '0;
         end else begin
            pf_word_n  = bus.q_b1_i;
            pf_valid_n = 1'b1;
         end
      end

      // One read outstanding at a time, and only into a guaranteed free slot.
      if ((state_n == S_RUN) && (issued_n < cnt_n) && !ce_q && !pf_valid_n) begin
         ce_n     = 1'b1;
         addr_n   = AWIDTH'(issued_n);
         issued_n = issued_n + WCW'(1);
      end

      if (cur_valid_n) begin
         m_data_n = lane_sel(cur_word_n, lane_n);
         m_last_n = (lane_n == 2'd3) && (retired_n == (cnt_n - WCW'(1)));
      end

      idle_n = (state_n == S_IDLE);
      run_n  = (state_n == S_RUN);
      done_n = (state_n == S_DONE);
   end

   assign idle_o        = idle_q;
   assign run_o         = run_q;
   assign done_o        = done_q;
   assign bus.addr_b1_o = addr_q;
   assign bus.ce_b1_o   = ce_q;
   assign bus.we_b1_o   = 1'b0;
   assign bus.m_valid_o = cur_valid_q;
   assign bus.m_data_o  = m_data_q;
   assign bus.m_last_o  = m_last_q;

endmodule

// File: tb/tb_bram1_result_reader.sv
// Directed bench for bram1_result_reader with a one-cycle-latency BRAM1 model.
module tb_bram1_result_reader;

   localparam int unsigned CNT_BIT = 31;
   localparam int unsigned DW      = 64;
   localparam int unsigned AW      = 8;
   localparam int unsigned MS      = 256;
   localparam int unsigned OW      = 16;

   logic               clk = 1'b0;
   logic               reset;
   logic               start_run_i;
   logic [CNT_BIT-1:0] run_count_i;
   logic               idle_o, run_o, done_o;

   bram1_result_reader_if #(.DWIDTH_2(DW), .AWIDTH(AW)) bus ();

   bram1_result_reader #(
      .CNT_BIT(CNT_BIT), .DWIDTH_2(DW), .AWIDTH(AW), .MEM_SIZE(MS)
   ) dut (
      .clk(clk), .reset(reset), .start_run_i(start_run_i),
      .run_count_i(run_count_i), .idle_o(idle_o), .run_o(run_o),
      .done_o(done_o), .bus(bus)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] mem [MS];

   always @(posedge clk) begin
      if (bus.ce_b1_o) bus.q_b1_i <= mem[bus.addr_b1_o];
   end

   int n_cmp = 0;
   int n_bad = 0;

   logic [OW-1:0] exp3 [12] = '{16'h0001, 16'h0003, 16'h0005, 16'h0007,
                                16'h0002, 16'h0004, 16'h0006, 16'h0008,
                                16'h0003, 16'h0005, 16'h0007, 16'h0009};

   // Results gathered by drain()
   logic [OW-1:0] got_data [$];
   logic          got_last [$];
   int            got_cyc  [$];
   int            hits [MS];
   int            n_reads, done_cnt, done_cyc, idle_cyc, stall_viol, ce_viol, timeout;
   logic          c1_run, c1_ce;
   logic [AW-1:0] c1_addr;

   task automatic fill_pattern();
      for (int i = 0; i < int'(MS); i++) mem[i] = '0;
      for (int i = 0; i < 5; i++)
         mem[i] = {16'(1 + i), 16'(3 + i), 16'(5 + i), 16'(7 + i)};
   endtask

   // Start a run and record lanes, reads and flags until idle returns.
   task automatic drain(input int cnt, input bit rand_ready, input int restart_at);
      logic          pv, pr, pl;
      logic [OW-1:0] pd;
      int            cyc, xfer, retired;
      got_data.delete(); got_last.delete(); got_cyc.delete();
      for (int i = 0; i < int'(MS); i++) hits[i] = 0;
      n_reads = 0; done_cnt = 0; done_cyc = -1; idle_cyc = -1;
      stall_viol = 0; ce_viol = 0; timeout = 0;
      pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; xfer = 0; retired = 0; cyc = 0;
      @(negedge clk);
      start_run_i   = 1'b1;
      run_count_i   = CNT_BIT'(cnt);
      bus.m_ready_i = 1'b1;
      forever begin
         @(negedge clk);
         cyc++;
         start_run_i = (cyc == restart_at);
         if (cyc == 1) begin
            c1_run = run_o; c1_ce = bus.ce_b1_o; c1_addr = bus.addr_b1_o;
         end
         if (done_o) begin done_cnt++; done_cyc = cyc; end
         if (pv && !pr && (!bus.m_valid_o || bus.m_data_o !== pd || bus.m_last_o !== pl))
            stall_viol++;
         bus.m_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (bus.ce_b1_o) begin
            if ((n_reads - retired) >= 2 &&
                !(bus.m_valid_o && bus.m_ready_i && (xfer % 4 == 3)))
               ce_viol++;
            hits[bus.addr_b1_o]++;
            n_reads++;
         end
         if (bus.m_valid_o && bus.m_ready_i) begin
            got_data.push_back(bus.m_data_o);
            got_last.push_back(bus.m_last_o);
            got_cyc.push_back(cyc);
            if (xfer % 4 == 3) retired++;
            xfer++;
         end
         pv = bus.m_valid_o; pr = bus.m_ready_i; pd = bus.m_data_o; pl = bus.m_last_o;
         if (idle_o && done_cnt > 0) begin idle_cyc = cyc; break; end
         if (cyc > 3000) begin timeout = 1; break; end
      end
      start_run_i   = 1'b0;
      bus.m_ready_i = 1'b1;
   endtask

   task automatic test_reset();
      logic [30:0] obs;
      reset = 1'b1; start_run_i = 1'b0; run_count_i = '0; bus.m_ready_i = 1'b1;
      repeat (2) @(negedge clk);
      obs = {idle_o, run_o, done_o, bus.ce_b1_o, bus.we_b1_o, bus.m_valid_o,
             bus.m_last_o, bus.addr_b1_o, bus.m_data_o};
      n_cmp++;
      if (obs !== {1'b1, 6'b0, 8'h00, 16'h0000}) begin
         n_bad++; $display("FAIL reset_outputs: got %h expected %h", obs, {1'b1, 30'h0});
      end
      reset = 1'b0;
   endtask

   task automatic test_basic();
      int bad = 0, lasts = 0;
      fill_pattern();
      drain(3, 1'b0, -1);
      n_cmp++; if (timeout !== 0) begin n_bad++; $display("FAIL basic_timeout: got %0d expected 0", timeout); end
      n_cmp++; if ({c1_run, c1_ce, c1_addr} !== {1'b1, 1'b1, 8'h00}) begin
         n_bad++; $display("FAIL basic_first_read: got run=%0b ce=%0b addr=%0h expected 1 1 0", c1_run, c1_ce, c1_addr);
      end
      n_cmp++; if (got_data.size() !== 12) begin n_bad++; $display("FAIL basic_lane_count: got %0d expected 12", got_data.size()); end
      for (int k = 0; k < got_data.size() && k < 12; k++) begin
         if (got_data[k] !== exp3[k]) bad++;
         if (got_cyc[k] !== 3 + k) bad++;
         if (got_last[k]) lasts++;
      end
      n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL basic_lanes: got %0d bad lanes expected 0", bad); end
      n_cmp++; if (got_last.size() != 12 || lasts !== 1 || got_last[11] !== 1'b1) begin
         n_bad++; $display("FAIL basic_last: got %0d last flags expected 1 on lane 12", lasts);
      end
      n_cmp++; if (done_cnt !== 1 || done_cyc !== 15) begin
         n_bad++; $display("FAIL basic_done: got %0d pulses at %0d expected 1 at 15", done_cnt, done_cyc);
      end
      n_cmp++; if (idle_cyc !== 16) begin n_bad++; $display("FAIL basic_idle: got %0d expected 16", idle_cyc); end
      n_cmp++; if (n_reads !== 3 || hits[0] !== 1 || hits[1] !== 1 || hits[2] !== 1) begin
         n_bad++; $display("FAIL basic_reads: got %0d reads expected 3", n_reads);
      end
   endtask

   task automatic test_long();
      int bad = 0, badaddr = 0;
      for (int i = 0; i < int'(MS); i++) mem[i] = 64'h0001_0003_0005_0007;
      drain(255, 1'b0, -1);
      n_cmp++; if (got_data.size() !== 1020) begin n_bad++; $display("FAIL long_lane_count: got %0d expected 1020", got_data.size()); end
      for (int k = 0; k < got_data.size(); k++) begin
         case (k % 4)
            0: if (got_data[k] !== 16'h0001) bad++;
            1: if (got_data[k] !== 16'h0003) bad++;
            2: if (got_data[k] !== 16'h0005) bad++;
            default: if (got_data[k] !== 16'h0007) bad++;
         endcase
      end
      n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL long_lanes: got %0d bad lanes expected 0", bad); end
      n_cmp++; if (got_cyc.size() != 1020 || got_cyc[1019] - got_cyc[0] !== 1019) begin
         n_bad++; $display("FAIL long_gapless: got span %0d expected 1019",
                           (got_cyc.size() > 0) ? got_cyc[got_cyc.size()-1] - got_cyc[0] : -1);
      end
      for (int i = 0; i < int'(MS); i++) if (hits[i] !== ((i < 255) ? 1 : 0)) badaddr++;
      n_cmp++; if (badaddr !== 0 || n_reads !== 255) begin
         n_bad++; $display("FAIL long_addresses: got %0d reads, %0d bad addrs expected 255, 0", n_reads, badaddr);
      end
   endtask

   task automatic test_stall();
      int bad = 0;
      fill_pattern();
      drain(3, 1'b1, -1);
      n_cmp++; if (got_data.size() !== 12) begin n_bad++; $display("FAIL stall_lane_count: got %0d expected 12", got_data.size()); end
      for (int k = 0; k < got_data.size() && k < 12; k++) begin
         if (got_data[k] !== exp3[k]) bad++;
         if (got_last[k] !== (k == 11)) bad++;
      end
      n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL stall_lanes: got %0d bad lanes expected 0", bad); end
      n_cmp++; if (stall_viol !== 0) begin n_bad++; $display("FAIL stall_hold: got %0d unstable cycles expected 0", stall_viol); end
      n_cmp++; if (ce_viol !== 0) begin n_bad++; $display("FAIL stall_ce_full: got %0d reads into full slot expected 0", ce_viol); end
      n_cmp++; if (done_cnt !== 1 || n_reads !== 3) begin
         n_bad++; $display("FAIL stall_done_reads: got %0d done %0d reads expected 1 3", done_cnt, n_reads);
      end
   endtask

   task automatic test_zero_and_clamp();
      int badaddr = 0;
      drain(0, 1'b0, -1);
      n_cmp++; if (n_reads !== 0 || got_data.size() !== 0) begin
         n_bad++; $display("FAIL zero_activity: got %0d reads %0d lanes expected 0 0", n_reads, got_data.size());
      end
      n_cmp++; if (done_cyc !== 1 || idle_cyc !== 2) begin
         n_bad++; $display("FAIL zero_timing: got done %0d idle %0d expected 1 2", done_cyc, idle_cyc);
      end
      for (int i = 0; i < int'(MS); i++) mem[i] = {16'(i), 16'(i), 16'(i), 16'h00ff};
      drain(1000, 1'b0, -1);
      for (int i = 0; i < int'(MS); i++) if (hits[i] !== 1) badaddr++;
      n_cmp++; if (n_reads !== 256 || badaddr !== 0) begin
         n_bad++; $display("FAIL clamp_reads: got %0d reads, %0d bad addrs expected 256, 0", n_reads, badaddr);
      end
      n_cmp++; if (got_data.size() !== 1024) begin n_bad++; $display("FAIL clamp_lane_count: got %0d expected 1024", got_data.size()); end
      n_cmp++; if (got_data.size() != 1024 || got_data[1020] !== 16'h00ff || got_data[1023] !== 16'h00ff
                   || got_last[1023] !== 1'b1 || got_last[1019] !== 1'b0) begin
         n_bad++; $display("FAIL clamp_final_word: got final word/last flags wrong expected 00ff with last");
      end
   endtask

   task automatic test_reset_mid();
      int xfer = 0, seen = 0, bad = 0;
      logic [30:0] obs;
      fill_pattern();
      @(negedge clk);
      start_run_i = 1'b1; run_count_i = CNT_BIT'(5); bus.m_ready_i = 1'b1;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         start_run_i = 1'b0;
         if (bus.m_valid_o && bus.m_ready_i) xfer++;
         if (xfer == 9) break;
      end
      n_cmp++; if (xfer !== 9) begin n_bad++; $display("FAIL midreset_reach: got %0d lanes expected 9", xfer); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      obs = {idle_o, run_o, done_o, bus.ce_b1_o, bus.we_b1_o, bus.m_valid_o,
             bus.m_last_o, bus.addr_b1_o, bus.m_data_o};
      n_cmp++;
      if (obs !== {1'b1, 6'b0, 8'h00, 16'h0000}) begin
         n_bad++; $display("FAIL midreset_outputs: got %h expected %h", obs, {1'b1, 30'h0});
      end
      repeat (6) begin
         @(negedge clk);
         if (bus.m_valid_o !== 1'b0 || idle_o !== 1'b1) seen++;
      end
      n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL midreset_quiet: got %0d active cycles expected 0", seen); end
      drain(3, 1'b0, -1);
      for (int k = 0; k < got_data.size() && k < 12; k++) if (got_data[k] !== exp3[k]) bad++;
      n_cmp++; if (got_data.size() !== 12 || bad !== 0 || c1_addr !== 8'h00) begin
         n_bad++; $display("FAIL midreset_restart: got %0d lanes %0d bad expected 12 0", got_data.size(), bad);
      end
   endtask

   task automatic test_restart_ignored();
      int bad = 0;
      fill_pattern();
      drain(3, 1'b0, 5);
      for (int k = 0; k < got_data.size() && k < 12; k++) if (got_data[k] !== exp3[k]) bad++;
      n_cmp++; if (got_data.size() !== 12 || bad !== 0) begin
         n_bad++; $display("FAIL restart_lanes: got %0d lanes %0d bad expected 12 0", got_data.size(), bad);
      end
      n_cmp++; if (done_cnt !== 1 || done_cyc !== 15 || idle_cyc !== 16) begin
         n_bad++; $display("FAIL restart_timing: got done %0d@%0d idle %0d expected 1@15 16", done_cnt, done_cyc, idle_cyc);
      end
      n_cmp++; if (n_reads !== 3) begin n_bad++; $display("FAIL restart_reads: got %0d expected 3", n_reads); end
   endtask

   initial begin
      reset = 1'b1; start_run_i = 1'b0; run_count_i = '0; bus.m_ready_i = 1'b1;
      fill_pattern();
      test_reset();
      test_basic();
      test_long();
      test_stall();
      test_zero_and_clamp();
      test_reset_mid();
      test_restart_ignored();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
